// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the data memory.
//
// Port 0 is the CPU load/store path, port 1 the loader/debug path. Each transaction walks
// IDLE (sample + latch) -> ACCESS (memory strobe, one cycle) -> RESP (done pulse, one cycle).
// Out-of-range or malformed accesses are flagged as errors and never strobe the memory.
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-low reset
//   reqN_i/weN_i/addrN_i/
//   wdataN_i/numN_i/unsN_i      per-port request, store flag, byte address, data, size, unsigned
//   gntN_o / doneN_o            grant during ACCESS, one-cycle completion pulse in RESP
//   rdata_o / err_o             shared load result and reject flag, valid with a done
//   mem_*_o / mem_rdata_i       memory port (combinational read data)
//
// Build option: define DMEM_ALIGN_CHECK_EN to also reject misaligned half/word accesses.

module dmem_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic [1:0]  num0_i,
  input  logic        uns0_i,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata1_i,
  input  logic [1:0]  num1_i,
  input  logic        uns1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [1:0]  mem_num_o,
  output logic        mem_unsigned_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;   // last granted port
  logic        id_q, id_d;       // owner of the current transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  num_q, num_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Arbitration and operand selection for the request being sampled in IDLE.
  logic        win;
  logic [31:0] sel_addr;
  logic [1:0]  sel_num;
  logic [32:0] sel_bytes;
  logic [32:0] last_byte;
  logic        sel_err;

  always_comb begin
    if (req0_i && req1_i) begin
      win = ~last_q;
    end else begin
      win = req1_i;
    end
    sel_addr = win ? addr1_i : addr0_i;
    sel_num  = win ? num1_i  : num0_i;
    unique case (sel_num)
      2'b11:   sel_bytes = 33'd4;
      2'b10:   sel_bytes = 33'd2;
      default: sel_bytes = 33'd1;
    endcase
    // 33-bit sum so addresses near the top of the 32-bit space cannot wrap into range.
    last_byte = {1'b0, sel_addr} + sel_bytes - 33'd1;
    sel_err   = (sel_num == 2'b00) || (last_byte > (33'(DEPTH) - 33'd1));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((sel_num == 2'b11 && sel_addr[1:0] != 2'b00) ||
        (sel_num == 2'b10 && sel_addr[0])) begin
      sel_err = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      num_q   <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      num_q   <= num_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    num_d   = num_q;
    uns_d   = uns_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          state_d = StAccess;
          last_d  = win;
          id_d    = win;
          we_d    = win ? we1_i    : we0_i;
          addr_d  = sel_addr;
          wdata_d = win ? wdata1_i : wdata0_i;
          num_d   = sel_num;
          uns_d   = win ? uns1_i   : uns0_i;
          err_d   = sel_err;
        end
      end
      StAccess: begin
        state_d = StResp;
        rdata_d = (!we_q && !err_q) ? mem_rdata_i : '0;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    gnt0_o         = (state_q == StAccess) && !id_q;
    gnt1_o         = (state_q == StAccess) &&  id_q;
    done0_o        = (state_q == StResp)   && !id_q;
    done1_o        = (state_q == StResp)   &&  id_q;
    err_o          = (state_q == StResp)   && err_q;
    rdata_o        = (state_q == StResp)   ? rdata_q : '0;
    mem_read_o     = (state_q == StAccess) && !err_q && !we_q;
    mem_write_o    = (state_q == StAccess) && !err_q &&  we_q;
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    mem_num_o      = num_q;
    mem_unsigned_o = uns_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_i, we0_i, uns0_i, req1_i, we1_i, uns1_i;
  logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
  logic [1:0]  num0_i, num1_i;
  logic        gnt0_o, gnt1_o, done0_o, done1_o, err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_o, mem_write_o, mem_unsigned_o;
  logic [1:0]  mem_num_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .num0_i(num0_i), .uns0_i(uns0_i),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .num1_i(num1_i), .uns1_i(uns1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .done0_o(done0_o), .done1_o(done1_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_num_o(mem_num_o), .mem_unsigned_o(mem_unsigned_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Little-endian byte memory model.
  always_comb begin
    logic [31:0] w;
    int unsigned idx;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      idx = mem_addr_o + 32'(i);
      if (idx < DEPTH) w[8*i +: 8] = mem[idx[9:0]];
    end
    case (mem_num_o)
      2'b01:   w = mem_unsigned_o ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b10:   w = mem_unsigned_o ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: w = w;
    endcase
    mem_rdata_i = w;
  end

  always @(posedge clk) begin
    if (mem_write_o) begin
      for (int i = 0; i < 4; i++) begin
        int unsigned idx;
        idx = mem_addr_o + 32'(i);
        if ((i < 1 || (i < 2 && mem_num_o[1]) || mem_num_o == 2'b11) && idx < DEPTH)
          mem[idx[9:0]] <= mem_wdata_o[8*i +: 8];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on port p, starting and ending in IDLE.
  task automatic txn(input string tag, input logic p, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] n, input logic u,
                     input logic exp_err, input logic [31:0] exp_rdata);
    if (!p) begin
      req0_i = 1; we0_i = we; addr0_i = a; wdata0_i = wd; num0_i = n; uns0_i = u;
    end else begin
      req1_i = 1; we1_i = we; addr1_i = a; wdata1_i = wd; num1_i = n; uns1_i = u;
    end
    cyc();
    chk({tag, " gnt"}, {30'b0, gnt1_o, gnt0_o}, p ? 32'd2 : 32'd1);
    chk({tag, " acc_done"}, {30'b0, done1_o, done0_o}, 32'd0);
    chk({tag, " acc_strobes"}, {30'b0, mem_read_o, mem_write_o},
        exp_err ? 32'd0 : (we ? 32'd1 : 32'd2));
    cyc();
    chk({tag, " done"}, {30'b0, done1_o, done0_o}, p ? 32'd2 : 32'd1);
    chk({tag, " resp_gnt_strobes"}, {28'b0, gnt1_o, gnt0_o, mem_read_o, mem_write_o}, 32'd0);
    chk({tag, " err"}, {31'b0, err_o}, {31'b0, exp_err});
    chk({tag, " rdata"}, rdata_o, exp_rdata);
    req0_i = 0;
    req1_i = 0;
    cyc();
    chk({tag, " idle"}, {28'b0, done1_o, done0_o, mem_read_o, mem_write_o}, 32'd0);
  endtask

  initial begin
    rst_i = 0;
    req0_i = 0; we0_i = 0; addr0_i = 0; wdata0_i = 0; num0_i = 0; uns0_i = 0;
    req1_i = 0; we1_i = 0; addr1_i = 0; wdata1_i = 0; num1_i = 0; uns1_i = 0;
    cyc();
    cyc();
    chk("rst ctl", {26'b0, gnt0_o, gnt1_o, done0_o, done1_o, err_o, mem_read_o}, 32'd0);
    chk("rst rdata", rdata_o, 32'd0);
    chk("rst maddr", mem_addr_o, 32'd0);
    rst_i = 1;

    txn("st0", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0, 32'h0);
    txn("ld0", 1'b0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 1'b0, 32'hDEAD_BEEF);
    txn("st1w", 1'b1, 1'b1, 32'h14, 32'h5566_7788, 2'b11, 1'b0, 1'b0, 32'h0);
    txn("st1b", 1'b1, 1'b1, 32'd1023, 32'h80, 2'b01, 1'b0, 1'b0, 32'h0);
    txn("ld1b", 1'b1, 1'b0, 32'd1023, 32'h0, 2'b01, 1'b0, 1'b0, 32'hFFFF_FF80);
    txn("ld1w_oor", 1'b1, 1'b0, 32'd1021, 32'h0, 2'b11, 1'b0, 1'b1, 32'h0);
    txn("ld1h_wrap", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0);
    txn("num00", 1'b0, 1'b1, 32'h40, 32'h1234, 2'b00, 1'b0, 1'b1, 32'h0);
    txn("ld0h_uns", 1'b0, 1'b0, 32'h12, 32'h0, 2'b10, 1'b1, 1'b0, 32'h0000_DEAD);
`ifdef DMEM_ALIGN_CHECK_EN
    txn("ld0w_mis", 1'b0, 1'b0, 32'h12, 32'h0, 2'b11, 1'b0, 1'b1, 32'h0);
`else
    txn("ld0w_mis", 1'b0, 1'b0, 32'h12, 32'h0, 2'b11, 1'b0, 1'b0, 32'h7788_DEAD);
`endif

    // Contention from reset: grants alternate 0,1,0,1 with a done every 3 cycles.
    rst_i = 0;
    req0_i = 1; we0_i = 0; addr0_i = 32'h10; num0_i = 2'b11; uns0_i = 0;
    req1_i = 1; we1_i = 0; addr1_i = 32'h10; num1_i = 2'b01; uns1_i = 1;
    cyc();
    rst_i = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rr%0d gnt", k), {30'b0, gnt1_o, gnt0_o}, (k % 2 == 1) ? 32'd2 : 32'd1);
      cyc();
      chk($sformatf("rr%0d done", k), {30'b0, done1_o, done0_o},
          (k % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("rr%0d rdata", k), rdata_o, (k % 2 == 1) ? 32'hEF : 32'hDEAD_BEEF);
      cyc();
      chk($sformatf("rr%0d idle", k), {30'b0, done1_o, done0_o}, 32'd0);
    end
    req0_i = 0;
    req1_i = 0;
    cyc();

    // Reset during ACCESS of a port 1 store.
    req1_i = 1; we1_i = 1; addr1_i = 32'h20; wdata1_i = 32'h1122_3344; num1_i = 2'b11;
    cyc();
    chk("rstmid gnt1", {31'b0, gnt1_o}, 32'd1);
    rst_i = 0;
    req1_i = 0;
    cyc();
    chk("rstmid ctl", {25'b0, gnt0_o, gnt1_o, done0_o, done1_o, err_o, mem_read_o,
        mem_write_o}, 32'd0);
    chk("rstmid rdata", rdata_o, 32'd0);
    chk("rstmid mem", mem_addr_o | mem_wdata_o | {29'b0, mem_num_o, mem_unsigned_o}, 32'd0);
    rst_i = 1;
    req0_i = 1; we0_i = 0; addr0_i = 32'h10; num0_i = 2'b11;
    req1_i = 1; we1_i = 0;
    cyc();
    chk("post_rst gnt", {30'b0, gnt1_o, gnt0_o}, 32'd1);
    cyc();
    chk("post_rst done", {30'b0, done1_o, done0_o}, 32'd1);
    req0_i = 0;
    req1_i = 0;
    cyc();
    cyc();
    chk("final quiet", {30'b0, gnt1_o, gnt0_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
